// File: rtl/acc_lut_pkg.sv
// Shared constants, state type and default-content function for the accumulator LUT bank.
// Optional write lock on entries 0..3 is selected by defining ACC_LUT_WRLOCK_EN.
package acc_lut_pkg;

   localparam int unsigned ACC_MAX_IDX  = 0;
   localparam int unsigned ACC_63_IDX   = 1;
   localparam int unsigned ACC_ZERO_IDX = 2;
   localparam int unsigned ACC_ONE_IDX  = 3;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      IDLE = 1'b1
   } acc_lut_state_e;

   // Returned wide; callers truncate to their entry width.
   function automatic logic [63:0] acc_lut_default(input int unsigned idx,
                                                   input int unsigned data_w);
      logic [63:0] ones;
      ones = (data_w >= 64) ? '1 : ((64'd1 << data_w) - 64'd1);
      case (idx)
         ACC_MAX_IDX:  return ones;
         ACC_63_IDX:   return 64'd63 & ones;
         ACC_ZERO_IDX: return 64'd0;
         ACC_ONE_IDX:  return 64'd1 & ones;
         default:      return 64'd0;
      endcase
   endfunction

endpackage

// File: rtl/acc_lut_init_seq.sv
// Initialisation sequencer: walks every entry once after reset or reinit, writing its default,
// and reports busy while the walk is in progress.
module acc_lut_init_seq
   import acc_lut_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned KEY_W  = 5,
   parameter int unsigned DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_reinit,
   output logic              o_busy,
   output logic              o_init_we,
   output logic [KEY_W-1:0]  o_init_key,
   output logic [DATA_W-1:0] o_init_data
);

   acc_lut_state_e   r_state;
   logic [KEY_W-1:0] r_idx;
   acc_lut_state_e   w_state_nxt;
   logic [KEY_W-1:0] w_idx_nxt;

   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_idx;
      case (r_state)
         INIT: begin
            if (r_idx == KEY_W'(DEPTH - 1)) begin
               w_state_nxt = IDLE;
               w_idx_nxt   = '0;
            end else begin
               w_idx_nxt = r_idx + KEY_W'(1);
            end
         end
         IDLE: begin
            if (i_reinit) begin
               w_state_nxt = INIT;
               w_idx_nxt   = '0;
            end
         end
         default: begin
            w_state_nxt = INIT;
            w_idx_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= INIT;
         r_idx   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_idx   <= w_idx_nxt;
      end
   end

   assign o_busy      = (r_state == INIT);
   assign o_init_we   = (r_state == INIT);
   assign o_init_key  = r_idx;
   assign o_init_data = DATA_W'(acc_lut_default(32'(r_idx), DATA_W));

endmodule

// File: rtl/acc_lut_bank.sv
// Programmable accumulator constant table with registered reads and write-first bypass.
// Defining ACC_LUT_WRLOCK_EN makes entries 0..3 read-only to host writes.
module acc_lut_bank
   import acc_lut_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned KEY_W  = 5,
   parameter int unsigned DEPTH  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              reinit,
   input  logic              rd_en,
   input  logic [KEY_W-1:0]  rd_key,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_miss,
   input  logic              wr_en,
   input  logic [KEY_W-1:0]  wr_key,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_err,
   output logic              busy
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rd_data;
   logic              r_rd_valid;
   logic              r_rd_miss;
   logic              r_wr_err;

   logic              w_busy;
   logic              w_init_we;
   logic [KEY_W-1:0]  w_init_key;
   logic [DATA_W-1:0] w_init_data;
   logic              w_rd_hit;
   logic              w_wr_hit;
   logic              w_wr_locked;
   logic              w_wr_ok;
   logic              w_rd_go;
   logic [DATA_W-1:0] w_rd_word;

   acc_lut_init_seq #(
      .DATA_W (DATA_W),
      .KEY_W  (KEY_W),
      .DEPTH  (DEPTH)
   ) u_init_seq (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_reinit    (reinit),
      .o_busy      (w_busy),
      .o_init_we   (w_init_we),
      .o_init_key  (w_init_key),
      .o_init_data (w_init_data)
   );

   assign w_rd_hit = 32'(rd_key) < DEPTH;
   assign w_wr_hit = 32'(wr_key) < DEPTH;

`ifdef ACC_LUT_WRLOCK_EN
   assign w_wr_locked = 32'(wr_key) <= ACC_ONE_IDX;
`else
   assign w_wr_locked = 1'b0;
`endif

   // A reinit request takes the table away from the host in the same cycle.
   assign w_wr_ok = wr_en && !w_busy && !reinit && w_wr_hit && !w_wr_locked;
   assign w_rd_go = rd_en && !w_busy;

   always_comb begin
      w_rd_word = '0;
      if (w_rd_hit) begin
         if (w_wr_ok && (wr_key == rd_key)) begin
            w_rd_word = wr_data;
         end else begin
            w_rd_word = r_mem[rd_key[AW-1:0]];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_init_we) begin
         r_mem[w_init_key[AW-1:0]] <= w_init_data;
      end else if (w_wr_ok) begin
         r_mem[wr_key[AW-1:0]] <= wr_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_data  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_miss  <= 1'b0;
         r_wr_err   <= 1'b0;
      end else begin
         r_rd_valid <= w_rd_go;
         r_rd_miss  <= w_rd_go && !w_rd_hit;
         r_wr_err   <= wr_en && !w_wr_ok;
         if (w_rd_go) begin
            r_rd_data <= w_rd_word;
         end
      end
   end

   assign rd_data  = r_rd_data;
   assign rd_valid = r_rd_valid;
   assign rd_miss  = r_rd_miss;
   assign wr_err   = r_wr_err;
   assign busy     = w_busy;

endmodule

// File: tb/tb_acc_lut_bank.sv
// Bench for acc_lut_bank: DEPTH=32 and DEPTH=20 instances share stimulus and are checked
// every cycle against an abstract table model.
module tb_acc_lut_bank;

`ifdef ACC_LUT_WRLOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic       clk;
   logic       rst_n;
   logic       reinit;
   logic       rd_en;
   logic [4:0] rd_key;
   logic       wr_en;
   logic [4:0] wr_key;
   logic [7:0] wr_data;

   logic [7:0] o_data  [2];
   logic       o_valid [2];
   logic       o_miss  [2];
   logic       o_err   [2];
   logic       o_busy  [2];

   int         total;
   int         bad;

   int         dep     [2];
   logic [7:0] mm      [2][32];
   int         blft    [2];
   logic [7:0] e_data  [2];
   logic       e_valid [2];
   logic       e_miss  [2];
   logic       e_err   [2];

   acc_lut_bank #(.DATA_W(8), .KEY_W(5), .DEPTH(32)) u_dut32 (
      .clk      (clk),
      .rst_n    (rst_n),
      .reinit   (reinit),
      .rd_en    (rd_en),
      .rd_key   (rd_key),
      .rd_data  (o_data[0]),
      .rd_valid (o_valid[0]),
      .rd_miss  (o_miss[0]),
      .wr_en    (wr_en),
      .wr_key   (wr_key),
      .wr_data  (wr_data),
      .wr_err   (o_err[0]),
      .busy     (o_busy[0])
   );

   acc_lut_bank #(.DATA_W(8), .KEY_W(5), .DEPTH(20)) u_dut20 (
      .clk      (clk),
      .rst_n    (rst_n),
      .reinit   (reinit),
      .rd_en    (rd_en),
      .rd_key   (rd_key),
      .rd_data  (o_data[1]),
      .rd_valid (o_valid[1]),
      .rd_miss  (o_miss[1]),
      .wr_en    (wr_en),
      .wr_key   (wr_key),
      .wr_data  (wr_data),
      .wr_err   (o_err[1]),
      .busy     (o_busy[1])
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] def_val(input int i);
      if (i == 0) return 8'hFF;
      if (i == 1) return 8'd63;
      if (i == 3) return 8'd1;
      return 8'd0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_default(input int d);
      for (int i = 0; i < 32; i++) mm[d][i] = def_val(i);
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         blft[d]    = dep[d];
         fill_default(d);
         e_data[d]  = 8'd0;
         e_valid[d] = 1'b0;
         e_miss[d]  = 1'b0;
         e_err[d]   = 1'b0;
      end
   endtask

   task automatic model_edge();
      bit idle;
      bit ok;
      for (int d = 0; d < 2; d++) begin
         idle = (blft[d] == 0);
         ok = wr_en && idle && !reinit && (int'(wr_key) < dep[d]) && !(LOCK && wr_key < 5'd4);
         e_valid[d] = rd_en && idle;
         e_err[d]   = wr_en && !ok;
         e_miss[d]  = e_valid[d] && (int'(rd_key) >= dep[d]);
         if (e_valid[d]) begin
            if (int'(rd_key) >= dep[d]) e_data[d] = 8'd0;
            else if (ok && wr_key == rd_key) e_data[d] = wr_data;
            else e_data[d] = mm[d][rd_key];
         end
         if (ok) mm[d][wr_key] = wr_data;
         if (!idle) blft[d]--;
         else if (reinit) begin
            blft[d] = dep[d];
            fill_default(d);
         end
      end
   endtask

   task automatic check_all(input string ph);
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("%s.d%0d.busy", ph, dep[d]), 32'(o_busy[d]), 32'(blft[d] != 0));
         chk($sformatf("%s.d%0d.valid", ph, dep[d]), 32'(o_valid[d]), 32'(e_valid[d]));
         chk($sformatf("%s.d%0d.miss", ph, dep[d]), 32'(o_miss[d]), 32'(e_miss[d]));
         chk($sformatf("%s.d%0d.err", ph, dep[d]), 32'(o_err[d]), 32'(e_err[d]));
         chk($sformatf("%s.d%0d.data", ph, dep[d]), 32'(o_data[d]), 32'(e_data[d]));
      end
   endtask

   task automatic step(input string ph, input logic re, input logic [4:0] rk, input logic we,
                       input logic [4:0] wk, input logic [7:0] wd, input logic ri);
      rd_en   = re;
      rd_key  = rk;
      wr_en   = we;
      wr_key  = wk;
      wr_data = wd;
      reinit  = ri;
      @(posedge clk);
      model_edge();
      #1;
      check_all(ph);
      rd_en  = 1'b0;
      wr_en  = 1'b0;
      reinit = 1'b0;
   endtask

   task automatic idle_cycles(input string ph, input int n);
      for (int i = 0; i < n; i++) step(ph, 1'b0, 5'd0, 1'b0, 5'd0, 8'd0, 1'b0);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      dep[0]  = 32;
      dep[1]  = 20;
      clk     = 1'b0;
      rst_n   = 1'b0;
      reinit  = 1'b0;
      rd_en   = 1'b0;
      rd_key  = 5'd0;
      wr_en   = 1'b0;
      wr_key  = 5'd0;
      wr_data = 8'd0;
      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Walk after reset; busy profile checked every cycle.
      idle_cycles("init", 32);
      chk("init.done", 32'(o_busy[0]), 32'd0);

      for (int k = 0; k < 4; k++) step("rd_const", 1'b1, 5'(k), 1'b0, 5'd0, 8'd0, 1'b0);
      step("rd17", 1'b1, 5'd17, 1'b0, 5'd0, 8'd0, 1'b0);
      chk("rd17.const", 32'(o_data[0]), 32'h00);

      step("wr5", 1'b0, 5'd0, 1'b1, 5'd5, 8'hA5, 1'b0);
      step("rd5", 1'b1, 5'd5, 1'b0, 5'd0, 8'd0, 1'b0);
      chk("rd5.const", 32'(o_data[0]), 32'hA5);
      step("bypass6", 1'b1, 5'd6, 1'b1, 5'd6, 8'h5A, 1'b0);
      chk("bypass6.const", 32'(o_data[0]), 32'h5A);

      step("rd25", 1'b1, 5'd25, 1'b0, 5'd0, 8'd0, 1'b0);
      chk("rd25.miss20", 32'(o_miss[1]), 32'd1);
      step("wr25", 1'b0, 5'd0, 1'b1, 5'd25, 8'hC3, 1'b0);
      chk("wr25.err20", 32'(o_err[1]), 32'd1);
      step("wr25.pulse", 1'b1, 5'd25, 1'b0, 5'd0, 8'd0, 1'b0);
      chk("wr25.pulse20", 32'(o_err[1]), 32'd0);

      step("wr10", 1'b0, 5'd0, 1'b1, 5'd10, 8'h77, 1'b0);
      step("reinit", 1'b1, 5'd10, 1'b1, 5'd11, 8'h99, 1'b1);
      step("busy.rd", 1'b1, 5'd3, 1'b0, 5'd0, 8'd0, 1'b0);
      step("busy.wr", 1'b0, 5'd0, 1'b1, 5'd4, 8'h44, 1'b0);
      idle_cycles("reinit.walk", 30);
      step("rd10", 1'b1, 5'd10, 1'b0, 5'd0, 8'd0, 1'b0);
      chk("rd10.const", 32'(o_data[0]), 32'h00);

      // Reset in the middle of a walk, at index 12.
      step("reinit2", 1'b0, 5'd0, 1'b0, 5'd0, 8'd0, 1'b1);
      idle_cycles("walk2", 12);
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      idle_cycles("init3", 32);
      step("rd1", 1'b1, 5'd1, 1'b0, 5'd0, 8'd0, 1'b0);
      chk("rd1.const", 32'(o_data[0]), 32'h3F);

      step("wr1", 1'b0, 5'd0, 1'b1, 5'd1, 8'h00, 1'b0);
      step("rd1b", 1'b1, 5'd1, 1'b0, 5'd0, 8'd0, 1'b0);
      step("wr4", 1'b0, 5'd0, 1'b1, 5'd4, 8'h12, 1'b0);
      step("rd4", 1'b1, 5'd4, 1'b0, 5'd0, 8'd0, 1'b0);
      chk("rd4.const", 32'(o_data[0]), 32'h12);

      for (int i = 0; i < 600; i++) begin
         logic [4:0] rk;
         logic [4:0] wk;
         rk = 5'($urandom_range(0, 31));
         wk = ($urandom_range(0, 2) == 0) ? rk : 5'($urandom_range(0, 31));
         step("rand", 1'($urandom_range(0, 1)), rk, 1'($urandom_range(0, 1)), wk,
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 59) == 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
